// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 Hz prescaler plus BCD HH:MM:SS timekeeper with set-mode strobes
module bcd_time_counter #(
   parameter int CLK_HZ = 50_000_000,
   parameter int PRE_W  = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       inc_min,
   input  logic       inc_hour,
   input  logic       clr_sec,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [3:0] hr_lo,
   output logic [3:0] hr_hi,
   output logic       sec_tick
);
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [3:0] sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
   logic [3:0] min_lo_q, min_lo_d, min_hi_q, min_hi_d;
   logic [3:0] hr_lo_q, hr_lo_d, hr_hi_q, hr_hi_d;
   logic sec_tick_q, sec_tick_d;
   logic tick, adv_sec, adv_min, adv_hr, sec_wrap, min_wrap, hr_wrap;
   assign tick     = run && (pre_q == PRE_W'(CLK_HZ - 1));
   assign sec_wrap = (sec_hi_q == 4'd5) && (sec_lo_q == 4'd9);
   assign min_wrap = (min_hi_q == 4'd5) && (min_lo_q == 4'd9);
   assign hr_wrap  = (hr_hi_q == 4'd2) && (hr_lo_q == 4'd3);
   // clr_sec beats a coincident tick, so the carry chain only starts from an unsuppressed tick
   assign adv_sec  = tick && !clr_sec;
   assign adv_min  = (adv_sec && sec_wrap) || (!run && inc_min);
   assign adv_hr   = (adv_sec && sec_wrap && min_wrap) || (!run && inc_hour);
   // next-state: prescaler, digit carry chain and set-mode increments
   always_comb begin
      pre_d      = (clr_sec || !run || tick) ? '0 : pre_q + PRE_W'(1);
      sec_lo_d   = clr_sec ? 4'd0 : adv_sec ? ((sec_lo_q == 4'd9) ? 4'd0 : sec_lo_q + 4'd1) : sec_lo_q;
      sec_hi_d   = clr_sec ? 4'd0 : (adv_sec && sec_lo_q == 4'd9) ? ((sec_hi_q == 4'd5) ? 4'd0 : sec_hi_q + 4'd1) : sec_hi_q;
      min_lo_d   = adv_min ? ((min_lo_q == 4'd9) ? 4'd0 : min_lo_q + 4'd1) : min_lo_q;
      min_hi_d   = (adv_min && min_lo_q == 4'd9) ? ((min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1) : min_hi_q;
      hr_lo_d    = adv_hr ? ((hr_wrap || hr_lo_q == 4'd9) ? 4'd0 : hr_lo_q + 4'd1) : hr_lo_q;
      hr_hi_d    = adv_hr ? (hr_wrap ? 4'd0 : (hr_lo_q == 4'd9) ? hr_hi_q + 4'd1 : hr_hi_q) : hr_hi_q;
      sec_tick_d = adv_sec;
   end
   // state registers with asynchronous clear to 00:00:00
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         sec_lo_q   <= 4'd0;
         sec_hi_q   <= 4'd0;
         min_lo_q   <= 4'd0;
         min_hi_q   <= 4'd0;
         hr_lo_q    <= 4'd0;
         hr_hi_q    <= 4'd0;
         sec_tick_q <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         sec_lo_q   <= sec_lo_d;
         sec_hi_q   <= sec_hi_d;
         min_lo_q   <= min_lo_d;
         min_hi_q   <= min_hi_d;
         hr_lo_q    <= hr_lo_d;
         hr_hi_q    <= hr_hi_d;
         sec_tick_q <= sec_tick_d;
      end
   end
   assign sec_lo   = sec_lo_q;
   assign sec_hi   = sec_hi_q;
   assign min_lo   = min_lo_q;
   assign min_hi   = min_hi_q;
   assign hr_lo    = hr_lo_q;
   assign hr_hi    = hr_hi_q;
   assign sec_tick = sec_tick_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: randomized and directed checks against a seconds-of-day model
module tb_bcd_time_counter;
   localparam int HZ = 4;
   logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, inc_min = 1'b0, inc_hour = 1'b0, clr_sec = 1'b0;
   logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
   logic sec_tick;
   logic [23:0] dut_t;
   int total = 0, bad = 0;
   int m_t = 0, m_pre = 0;
   bit m_tick = 1'b0;

   bcd_time_counter #(.CLK_HZ(HZ), .PRE_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
      .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi), .hr_lo(hr_lo), .hr_hi(hr_hi),
      .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;
   assign dut_t = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

   function automatic logic [23:0] enc(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic step(input bit r, input bit im, input bit ih, input bit cs);
      int h, m;
      bit tk;
      run = r; inc_min = im; inc_hour = ih; clr_sec = cs;
      @(posedge clk);
      tk = r && (m_pre == HZ - 1);
      m_tick = tk && !cs;
      if (cs) m_t = m_t - m_t % 60;
      else if (tk) m_t = (m_t + 1) % 86400;
      if (!r && im) begin
         m = (m_t / 60) % 60;
         m_t = m_t - m * 60 + ((m + 1) % 60) * 60;
      end
      if (!r && ih) begin
         h = m_t / 3600;
         m_t = m_t - h * 3600 + ((h + 1) % 24) * 3600;
      end
      m_pre = (cs || !r || tk) ? 0 : m_pre + 1;
      #1;
      inc_min = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0;
   endtask

   task automatic hard_reset();
      #2 rst_n = 1'b0;
      m_t = 0; m_pre = 0; m_tick = 1'b0;
      #1;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (dut_t !== 24'h000000 || sec_tick !== 1'b0) begin
         bad++;
         $display("FAIL reset: digits=%h tick=%b need 000000 tick=0", dut_t, sec_tick);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_count();
      int ticks = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1, 0, 0, 0);
         ticks += int'(sec_tick);
         total++;
         if (dut_t !== enc(m_t) || sec_tick !== m_tick || sec_tick !== (i % 4 == 0)) begin
            bad++;
            $display("FAIL count c%0d: digits=%h tick=%b need %h tick=%b", i, dut_t, sec_tick, enc(m_t), m_tick);
         end
      end
      total++;
      if (ticks != 3 || dut_t !== 24'h000003) begin
         bad++;
         $display("FAIL count_total: ticks=%0d digits=%h need 3 ticks 000003", ticks, dut_t);
      end
   endtask

   task automatic test_set();
      step(0, 0, 0, 1);
      for (int i = 0; i < 23; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
      for (int i = 0; i < 59; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
      total++;
      if (dut_t !== 24'h235900 || dut_t !== enc(m_t)) begin
         bad++;
         $display("FAIL set_2359: digits=%h need 235900", dut_t);
      end
      step(0, 1, 0, 0);
      total++;
      if (dut_t !== 24'h230000 || dut_t !== enc(m_t) || sec_tick !== 1'b0) begin
         bad++;
         $display("FAIL set_minwrap: digits=%h tick=%b need 230000 tick=0", dut_t, sec_tick);
      end
      for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
   endtask

   task automatic test_rollover();
      for (int i = 0; i < 59 * HZ; i++) begin
         step(1, 0, 0, 0);
         total++;
         if (dut_t !== enc(m_t) || sec_tick !== m_tick) begin
            bad++;
            $display("FAIL roll_run c%0d: digits=%h tick=%b need %h tick=%b", i, dut_t, sec_tick, enc(m_t), m_tick);
         end
      end
      total++;
      if (dut_t !== 24'h235959) begin
         bad++;
         $display("FAIL roll_235959: digits=%h need 235959", dut_t);
      end
      for (int i = 0; i < HZ; i++) step(1, 0, 0, 0);
      total++;
      if (dut_t !== 24'h000000 || sec_tick !== 1'b1 || m_t != 0) begin
         bad++;
         $display("FAIL roll_wrap: digits=%h tick=%b need 000000 tick=1", dut_t, sec_tick);
      end
   endtask

   task automatic test_hour_carry();
      step(0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
      total++;
      if (dut_t !== 24'h090000) begin
         bad++;
         $display("FAIL hour_09: digits=%h need 090000", dut_t);
      end
      step(0, 0, 1, 0);
      total++;
      if (dut_t !== 24'h100000 || dut_t !== enc(m_t)) begin
         bad++;
         $display("FAIL hour_10: digits=%h need 100000", dut_t);
      end
      step(0, 1, 1, 0);
      total++;
      if (dut_t !== 24'h110100 || dut_t !== enc(m_t)) begin
         bad++;
         $display("FAIL hour_both: digits=%h need 110100", dut_t);
      end
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
      total++;
      if (dut_t !== 24'h200100) begin
         bad++;
         $display("FAIL hour_20: digits=%h need 200100", dut_t);
      end
   endtask

   task automatic test_clr_tick();
      hard_reset();
      for (int i = 0; i < 7 * HZ + HZ - 1; i++) step(1, 0, 0, 0);
      total++;
      if (dut_t !== 24'h000007) begin
         bad++;
         $display("FAIL clr_pre: digits=%h need 000007", dut_t);
      end
      step(1, 0, 0, 1);
      total++;
      if (dut_t !== 24'h000000 || sec_tick !== 1'b0 || dut_t !== enc(m_t)) begin
         bad++;
         $display("FAIL clr_on_tick: digits=%h tick=%b need 000000 tick=0", dut_t, sec_tick);
      end
      for (int i = 1; i <= HZ; i++) begin
         step(1, 0, 0, 0);
         total++;
         if (sec_tick !== (i == HZ) || sec_tick !== m_tick) begin
            bad++;
            $display("FAIL clr_next c%0d: tick=%b need %b", i, sec_tick, i == HZ);
         end
      end
   endtask

   task automatic test_reset_mid();
      hard_reset();
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
      for (int i = 0; i < 34; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 56 * HZ; i++) step(1, 0, 0, 0);
      total++;
      if (dut_t !== 24'h123456) begin
         bad++;
         $display("FAIL mid_pre: digits=%h need 123456", dut_t);
      end
      #2 rst_n = 1'b0;
      m_t = 0; m_pre = 0; m_tick = 1'b0;
      #1;
      total++;
      if (dut_t !== 24'h000000 || sec_tick !== 1'b0) begin
         bad++;
         $display("FAIL mid_async: digits=%h tick=%b need 000000 tick=0", dut_t, sec_tick);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3 * HZ; i++) begin
         step(1, i % 2 == 0, 0, 0);
         total++;
         if (dut_t !== enc(m_t) || {min_hi, min_lo} !== 8'h00) begin
            bad++;
            $display("FAIL mid_ignore c%0d: digits=%h need %h", i, dut_t, enc(m_t));
         end
      end
   endtask

   task automatic test_random();
      bit r;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9) < 7;
         step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
         total++;
         if (dut_t !== enc(m_t) || sec_tick !== m_tick) begin
            bad++;
            $display("FAIL random c%0d: digits=%h tick=%b need %h tick=%b", i, dut_t, sec_tick, enc(m_t), m_tick);
         end
         total++;
         if (sec_lo > 9 || min_lo > 9 || hr_lo > 9 || sec_hi > 5 || min_hi > 5 || hr_hi > 2 || (hr_hi == 2 && hr_lo > 3)) begin
            bad++;
            $display("FAIL invariant c%0d: digits=%h outside legal ranges", i, dut_t);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_set();
      test_rollover();
      test_hour_carry();
      test_clr_tick();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
